// File: rtl/common_types_pkg.sv
// Shared CPU datapath types: word width, fetch FSM encoding and PC helpers.
package common_types;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        VALID  = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
        return addr & {{(WORD_W-2){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/dyt_fetch_if.sv
// Bundle of the fetch unit's memory and decode-side signals, with one modport per side.
interface dyt_fetch_if;
    import common_types::*;

    logic              imem_req;
    logic [WORD_W-1:0] imem_addr;
    logic              imem_ready;
    logic [WORD_W-1:0] imem_rdata;
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_stall;
    logic              halt;
    logic              redirect;
    logic [WORD_W-1:0] redirect_pc;
    logic              halted;
    logic [31:0]       fetch_count;

    modport cpu (
        output imem_req, imem_addr, instr, instr_pc, instr_valid, halted, fetch_count,
        input  imem_ready, imem_rdata, instr_stall, halt, redirect, redirect_pc
    );

    modport tb (
        input  imem_req, imem_addr, instr, instr_pc, instr_valid, halted, fetch_count,
        output imem_ready, imem_rdata, instr_stall, halt, redirect, redirect_pc
    );

endinterface

// File: rtl/dyt_fetch_pc.sv
// Program counter register with next-PC selection: reset, redirect load, +4 step or hold.
module dyt_fetch_pc
    import common_types::*;
#(
    parameter logic [WORD_W-1:0] PC_INIT = 32'h0000_0000
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              inc_i,
    input  logic              load_i,
    input  logic [WORD_W-1:0] load_pc_i,
    output logic [WORD_W-1:0] pc_o
);

    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] pc_d;

    // A load always wins over a step so a redirect never advances past its target.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = word_align(load_pc_i);
        end else if (inc_i) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            pc_q <= word_align(PC_INIT);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/dyt_fetch.sv
// Instruction fetch unit: single-outstanding imem reads, one instruction presented to decode at a time.
module dyt_fetch
    import common_types::*;
#(
    parameter logic [WORD_W-1:0] PC_INIT = 32'h0000_0000
) (
    input  logic              CLK,
    input  logic              nRST,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_stall,
    input  logic              halt,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic              halted,
    output logic [31:0]       fetch_count,
    output fetch_state_t      dbg_state
);

    // Handshakes: memory transfers when imem_req & imem_ready (req held until then);
    // decode accepts when instr_valid & !instr_stall, and instr/instr_pc hold until it does.

    fetch_state_t      state_q, state_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic [WORD_W-1:0] instr_pc_q, instr_pc_d;
    logic              valid_q, valid_d;
    logic [31:0]       count_q, count_d;
    logic              armed_q;
    logic              pc_inc;
    logic              pc_load;
    logic [WORD_W-1:0] pc;
    logic              accept;

    dyt_fetch_pc #(
        .PC_INIT (PC_INIT)
    ) u_pc (
        .CLK       (CLK),
        .nRST      (nRST),
        .inc_i     (pc_inc),
        .load_i    (pc_load),
        .load_pc_i (redirect_pc),
        .pc_o      (pc)
    );

    assign accept = valid_q && !instr_stall;

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        count_d    = count_q;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;

        case (state_q)
            IDLE: begin
                // Stay one full cycle in IDLE after the first edge with reset released.
                if (armed_q) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (imem_ready) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc;
                    valid_d    = 1'b1;
                    pc_inc     = 1'b1;
                    state_d    = VALID;
                end
            end
            VALID: begin
                if (accept) begin
                    count_d = count_q + 32'd1;
                    valid_d = 1'b0;
                    state_d = halt ? HALTED : REQ;
                end
            end
            HALTED: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase

        // Redirect flushes whatever this cycle would have done, including a halt-accept.
        if (redirect && (state_q != HALTED)) begin
            instr_d    = instr_q;
            instr_pc_d = instr_pc_q;
            count_d    = count_q;
            valid_d    = 1'b0;
            pc_inc     = 1'b0;
            pc_load    = 1'b1;
            state_d    = REQ;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q    <= IDLE;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            count_q    <= '0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
            armed_q    <= 1'b1;
        end
    end

    assign imem_req    = (state_q == REQ);
    assign imem_addr   = pc;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;
    assign halted      = (state_q == HALTED);
    assign fetch_count = count_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_dyt_fetch.sv
// Directed bench for dyt_fetch: cycle-by-cycle checks plus a scoreboard of accepted {pc, instr} pairs.
module tb_dyt_fetch;
    import common_types::*;

    logic              CLK;
    logic              nRST;
    logic              imem_req;
    logic [WORD_W-1:0] imem_addr;
    logic              imem_ready;
    logic [WORD_W-1:0] imem_rdata;
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_stall;
    logic              halt;
    logic              redirect;
    logic [WORD_W-1:0] redirect_pc;
    logic              halted;
    logic [31:0]       fetch_count;
    fetch_state_t      dbg_state;

    logic              auto_ready;
    logic [63:0]       exp_q[$];
    int                checks;
    int                errors;

    dyt_fetch #(
        .PC_INIT (32'h0000_0100)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_stall (instr_stall),
        .halt        (halt),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halted      (halted),
        .fetch_count (fetch_count),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // memory model: word at address A is {A[15:0], 16'hBEEF}
    assign imem_ready = auto_ready & imem_req;
    assign imem_rdata = {imem_addr[15:0], 16'hBEEF};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    // monitor: every decode accept (not flushed by redirect) is scored
    always @(negedge CLK) begin
        if (nRST && instr_valid && !instr_stall && !redirect) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL accept_unexpected: got pc %h instr %h expected none", instr_pc, instr);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("accept_pc", instr_pc, e[63:32]);
                check("accept_instr", instr, e[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        checks      = 0;
        errors      = 0;
        nRST        = 1'b0;
        auto_ready  = 1'b1;
        instr_stall = 1'b0;
        halt        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;

        step();
        step();
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_count", fetch_count, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);

        // sequential fetch from PC_INIT, memory always ready
        exp_q.push_back({32'h0000_0100, 32'h0100_BEEF});
        exp_q.push_back({32'h0000_0104, 32'h0104_BEEF});
        exp_q.push_back({32'h0000_0108, 32'h0108_BEEF});
        nRST = 1'b1;
        step();                                   // E0
        check("idle_hold_req", 32'(imem_req), 32'd0);
        step();                                   // E1
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, 32'h0000_0100);
        step();                                   // E2
        check("first_valid", 32'(instr_valid), 32'd1);
        check("valid_no_req", 32'(imem_req), 32'd0);
        step();                                   // E3: accept 0x100
        check("count_1", fetch_count, 32'd1);
        check("addr_104", imem_addr, 32'h0000_0104);

        // three wait states at 0x104
        auto_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("wait_req", 32'(imem_req), 32'd1);
            check("wait_addr", imem_addr, 32'h0000_0104);
            check("wait_valid", 32'(instr_valid), 32'd0);
        end
        auto_ready = 1'b1;
        step();                                   // E7
        check("wait_done_valid", 32'(instr_valid), 32'd1);

        // four stalled cycles while VALID
        instr_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_instr", instr, 32'h0104_BEEF);
            check("stall_pc", instr_pc, 32'h0000_0104);
            check("stall_no_req", 32'(imem_req), 32'd0);
            check("stall_count", fetch_count, 32'd1);
        end
        instr_stall = 1'b0;
        step();                                   // E12: accept 0x104
        check("release_count", fetch_count, 32'd2);
        check("addr_108", imem_addr, 32'h0000_0108);
        step();                                   // E13
        step();                                   // E14: accept 0x108
        check("count_3", fetch_count, 32'd3);
        check("addr_10c", imem_addr, 32'h0000_010C);

        // redirect in the same cycle as imem_ready: data dropped
        exp_q.push_back({32'h0000_2000, 32'h2000_BEEF});
        redirect    = 1'b1;
        redirect_pc = 32'h0000_2003;
        step();                                   // E15
        redirect = 1'b0;
        check("redir_addr", imem_addr, 32'h0000_2000);
        check("redir_req", 32'(imem_req), 32'd1);
        check("redir_flush_valid", 32'(instr_valid), 32'd0);
        check("redir_count", fetch_count, 32'd3);
        step();                                   // E16
        step();                                   // E17: accept 0x2000
        check("count_4", fetch_count, 32'd4);

        // redirect to 0x10C, then halt on it
        exp_q.push_back({32'h0000_010C, 32'h010C_BEEF});
        redirect    = 1'b1;
        redirect_pc = 32'h0000_010C;
        step();                                   // E18
        redirect = 1'b0;
        check("addr_10c_redir", imem_addr, 32'h0000_010C);
        step();                                   // E19
        halt = 1'b1;
        step();                                   // E20: halt-accept
        halt = 1'b0;
        check("halted", 32'(halted), 32'd1);
        check("halted_req", 32'(imem_req), 32'd0);
        check("halted_valid", 32'(instr_valid), 32'd0);
        check("halt_count", fetch_count, 32'd5);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_3000;
        step();                                   // E21: redirect ignored
        redirect = 1'b0;
        check("halted_ignores_redir", 32'(halted), 32'd1);
        check("halted_ignores_req", 32'(imem_req), 32'd0);

        // one-edge reset restarts at PC_INIT
        exp_q.push_back({32'hFFFF_FFFC, 32'hFFFC_BEEF});
        nRST = 1'b0;
        step();                                   // E22
        check("rerst_halted", 32'(halted), 32'd0);
        check("rerst_count", fetch_count, 32'd0);
        nRST = 1'b1;
        step();                                   // E23
        check("rerst_idle", 32'(dbg_state), 32'(IDLE));
        step();                                   // E24
        check("restart_addr", imem_addr, 32'h0000_0100);
        step();                                   // E25: VALID 0x100

        // redirect beats a same-cycle halt-accept
        halt        = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();                                   // E26
        halt     = 1'b0;
        redirect = 1'b0;
        check("redir_halt_halted", 32'(halted), 32'd0);
        check("redir_halt_count", fetch_count, 32'd0);
        check("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
        step();                                   // E27: VALID 0xFFFFFFFC
        step();                                   // E28: accept, pc wraps
        check("wrap_count", fetch_count, 32'd1);
        check("wrap_addr", imem_addr, 32'h0000_0000);
        check("wrap_req", 32'(imem_req), 32'd1);

        step();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
